// File: rtl/req_enc_pkg.sv
// Shared constants, FSM state type and popcount helper for the req_encoder8 request encoder.
package req_enc_pkg;

    localparam int N_SRC = 8;
    localparam int IDX_W = 3;
    localparam int CNT_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    function automatic logic [CNT_W-1:0] popcount(input logic [N_SRC-1:0] v);
        logic [CNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < N_SRC; i++) begin
            cnt = cnt + CNT_W'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/req_encoder8_prio.sv
// prio_enc8: combinational circular priority encoder; the search starts at startIdx and wraps.
module prio_enc8
    import req_enc_pkg::*;
(
    input  logic [N_SRC-1:0] vec,
    input  logic [IDX_W-1:0] startIdx,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    logic [IDX_W-1:0] probe;

    // Walk offsets from farthest to nearest so the nearest set bit wins.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        probe = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            probe = startIdx + IDX_W'(i);
            if (vec[probe]) begin
                idx   = probe;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/req_encoder8.sv
// req_encoder8: accumulates multi-hot requests and hands them out one index at a time over a
// valid/ready slot. Define REQ_ENCODER8_ROUND_ROBIN_EN for round-robin selection instead of fixed priority.
module req_encoder8
    import req_enc_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             Eneable,
    input  logic [N_SRC-1:0] req,
    input  logic             out_ready,
    output logic [IDX_W-1:0] code,
    output logic             out_valid,
    output logic [CNT_W-1:0] pend_cnt,
    output logic             busy
);

    state_e           state_q, state_d;
    logic [N_SRC-1:0] pending_q, pending_d;
    logic [IDX_W-1:0] code_q, code_d;
    logic [CNT_W-1:0] cnt_q;

    logic [N_SRC-1:0] pendAll;
    logic [IDX_W-1:0] startIdx;
    logic [IDX_W-1:0] selIdx;
    logic             selFound;
    logic             slotFree;
    logic             load;

    assign pendAll  = pending_q | req;
    assign slotFree = (state_q == IDLE) || out_ready;
    assign load     = !Eneable && slotFree && selFound;

`ifdef REQ_ENCODER8_ROUND_ROBIN_EN
    logic [IDX_W-1:0] ptr_q;

    assign startIdx = ptr_q + IDX_W'(1);

    // Pointer remembers the last granted index; reset to 7 so the first search starts at 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= IDX_W'(N_SRC - 1);
        end else if (load) begin
            ptr_q <= selIdx;
        end
    end
`else
    assign startIdx = '0;
`endif

    prio_enc8 u_prio (
        .vec      (pendAll),
        .startIdx (startIdx),
        .idx      (selIdx),
        .found    (selFound)
    );

    always_comb begin
        pending_d = pendAll;
        code_d    = code_q;
        if (load) begin
            pending_d         = pendAll;
            pending_d[selIdx] = 1'b0;
            code_d            = selIdx;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: state_d = load ? HOLD : IDLE;
            HOLD: state_d = (out_ready && !load) ? IDLE : HOLD;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
            code_q    <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            code_q    <= code_d;
            cnt_q     <= popcount(pending_d);
        end
    end

    always_comb begin
        out_valid = (state_q == HOLD);
        code      = code_q;
        pend_cnt  = cnt_q;
        busy      = (state_q == HOLD) || (cnt_q != '0);
    end

endmodule

// File: tb/tb_req_encoder8.sv
// Directed table-driven bench for req_encoder8 with hand-written multi-cycle sequences.
module tb_req_encoder8;

    logic       clk;
    logic       rst;
    logic       Eneable;
    logic [7:0] req;
    logic       out_ready;
    logic [2:0] code;
    logic       out_valid;
    logic [3:0] pend_cnt;
    logic       busy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       rst;
        logic       en_n;
        logic [7:0] req;
        logic       rdy;
        logic [2:0] code;
        logic       valid;
        logic [3:0] cnt;
        logic       busy;
    } vec_t;

    vec_t vecs[$];

    req_encoder8 dut (
        .clk       (clk),
        .rst       (rst),
        .Eneable   (Eneable),
        .req       (req),
        .out_ready (out_ready),
        .code      (code),
        .out_valid (out_valid),
        .pend_cnt  (pend_cnt),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [2:0] expCode, input logic expValid,
                               input logic [3:0] expCnt, input logic expBusy);
        checks++;
        if (code !== expCode) begin
            errors++;
            $display("[TB] FAIL %s code: got %0d expected %0d", name, code, expCode);
        end
        checks++;
        if (out_valid !== expValid) begin
            errors++;
            $display("[TB] FAIL %s out_valid: got %b expected %b", name, out_valid, expValid);
        end
        checks++;
        if (pend_cnt !== expCnt) begin
            errors++;
            $display("[TB] FAIL %s pend_cnt: got %0d expected %0d", name, pend_cnt, expCnt);
        end
        checks++;
        if (busy !== expBusy) begin
            errors++;
            $display("[TB] FAIL %s busy: got %b expected %b", name, busy, expBusy);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic enN, input logic [7:0] rq, input logic rdy);
        @(negedge clk);
        rst       = r;
        Eneable   = enN;
        req       = rq;
        out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic addVec(input logic r, input logic enN, input logic [7:0] rq, input logic rdy,
                          input logic [2:0] c, input logic v, input logic [3:0] n, input logic b);
        vec_t t;
        t.rst = r; t.en_n = enN; t.req = rq; t.rdy = rdy;
        t.code = c; t.valid = v; t.cnt = n; t.busy = b;
        vecs.push_back(t);
    endtask

    initial begin
        rst = 1'b1; Eneable = 1'b0; req = '0; out_ready = 1'b1;

        // reset discards a simultaneous request
        addVec(1, 0, 8'hFF, 1, 0, 0, 0, 0);
        // single request, one-cycle latency, then slot empties
        addVec(0, 0, 8'h04, 1, 2, 1, 0, 1);
        addVec(0, 0, 8'h00, 1, 2, 0, 0, 0);
        // multi-hot 1000_0011 drains 0,1,7
        addVec(0, 0, 8'h83, 1, 0, 1, 2, 1);
        addVec(0, 0, 8'h00, 1, 1, 1, 1, 1);
        addVec(0, 0, 8'h00, 1, 7, 1, 0, 1);
        addVec(0, 0, 8'h00, 1, 7, 0, 0, 0);
        // disabled: accumulate all eight, then drain 0..7
        addVec(0, 1, 8'hFF, 1, 7, 0, 8, 1);
        addVec(0, 1, 8'h00, 1, 7, 0, 8, 1);
        for (int i = 0; i < 8; i++) begin
            addVec(0, 0, 8'h00, 1, 3'(i), 1, 4'(7 - i), 1);
        end
        addVec(0, 0, 8'h00, 1, 7, 0, 0, 0);
        // held grant still consumable while disabled
        addVec(0, 0, 8'h10, 1, 4, 1, 0, 1);
        addVec(0, 1, 8'h01, 0, 4, 1, 1, 1);
        addVec(0, 1, 8'h00, 1, 4, 0, 1, 1);
        addVec(0, 0, 8'h00, 1, 0, 1, 0, 1);
        addVec(0, 0, 8'h00, 1, 0, 0, 0, 0);
        // request on the bit being granted is absorbed
        addVec(0, 1, 8'h02, 1, 0, 0, 1, 1);
        addVec(0, 0, 8'h02, 1, 1, 1, 0, 1);
        addVec(0, 0, 8'h00, 1, 1, 0, 0, 0);
        // repeated request on a pending bit queues once
        addVec(0, 1, 8'h08, 1, 1, 0, 1, 1);
        addVec(0, 1, 8'h08, 1, 1, 0, 1, 1);
        addVec(0, 0, 8'h00, 1, 3, 1, 0, 1);
        addVec(0, 0, 8'h00, 1, 3, 0, 0, 0);

        $display("[TB] applying %0d table vectors", vecs.size());
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst, vecs[i].en_n, vecs[i].req, vecs[i].rdy);
            checkOutput($sformatf("vec%0d", i), vecs[i].code, vecs[i].valid, vecs[i].cnt, vecs[i].busy);
        end

        // grant 5 stalled for 4 cycles while bit 3 pulses
        applyStimulus(0, 0, 8'h20, 0);
        checkOutput("stall_load", 5, 1, 0, 1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, (i % 2 == 0) ? 8'h08 : 8'h00, 0);
            checkOutput($sformatf("stall%0d", i), 5, 1, 1, 1);
        end
        applyStimulus(0, 0, 8'h00, 1);
        checkOutput("stall_release", 3, 1, 0, 1);
        applyStimulus(0, 0, 8'h00, 1);
        checkOutput("stall_drain", 3, 0, 0, 0);

        // reset while a grant is held with three pending
        applyStimulus(0, 0, 8'h0F, 0);
        checkOutput("pre_reset", 0, 1, 3, 1);
        applyStimulus(1, 0, 8'hF0, 0);
        checkOutput("reset_pulse", 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 8'h00, 1);
            checkOutput($sformatf("post_reset%0d", i), 0, 0, 0, 0);
        end

        // request pair held high
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 8'h03, 1);
`ifdef REQ_ENCODER8_ROUND_ROBIN_EN
            checkOutput($sformatf("held_pair%0d", i), 3'(i % 2), 1, 1, 1);
`else
            checkOutput($sformatf("held_pair%0d", i), 0, 1, 1, 1);
`endif
        end
        applyStimulus(1, 0, 8'h00, 1);
        checkOutput("final_reset", 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/req_encoder8.md
REQ_ENCODER8 -- requirements
Module: req_encoder8

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 Eneable  input  1  grant enable, active-low (0 = grants allowed), same polarity as the 3-to-8 decoder enable.
REQ-004 req  input  8  request lines, one bit per source, multi-hot allowed, sampled every cycle.
REQ-005 out_ready  input  1  consumer accepts the current code when high with out_valid high.
REQ-006 code  output  3  registered binary index of the granted source.
REQ-007 out_valid  output  1  code holds an unconsumed grant.
REQ-008 pend_cnt  output  4  registered count of pending, not-yet-granted sources (0..8).
REQ-009 busy  output  1  high when out_valid=1 or pend_cnt!=0.

Function
REQ-010 Internal pending[7:0] register; each cycle it SHALL absorb req (set = pending | req).
REQ-011 Slot free: free = !out_valid || out_ready.
REQ-012 Load: Eneable=0, free=1 and (pending|req)!=0; on the edge code <= selected index, out_valid <= 1, pending <= (pending|req) with the selected bit cleared.
REQ-013 Selection covers pending|req, so a request asserted in cycle n SHALL appear on code/out_valid after the edge ending cycle n (1-cycle latency) if the slot is free.
REQ-014 Selection without round-robin: fixed priority, bit 0 highest, bit 7 lowest.
REQ-015 A request on the bit being granted in the same cycle SHALL be absorbed into that grant (served once).
REQ-016 A repeated request on a bit already pending SHALL NOT queue a second service.
REQ-017 free=1 and no load (nothing pending or Eneable=1): out_valid <= 0, code holds its last value.
REQ-018 out_valid=1 and out_ready=0: code and out_valid SHALL hold stable; pending keeps absorbing req.
REQ-019 Eneable=1 SHALL block new grants only; pending accumulation and consumption of a held grant continue.
REQ-020 pend_cnt SHALL equal popcount of the next-state pending, registered with it.
REQ-021 Two-state FSM: IDLE (out_valid=0), HOLD (out_valid=1); IDLE->HOLD on load; HOLD->HOLD on out_ready with load, or on !out_ready; HOLD->IDLE on out_ready without load.

Reset
REQ-022 rst=1 at an edge SHALL force code=0, out_valid=0, pending=0, pend_cnt=0, busy=0, FSM=IDLE, round-robin pointer=7, discarding any held grant.
REQ-023 req sampled in a cycle with rst=1 SHALL be discarded.

Configuration
REQ-024 Macro REQ_ENCODER8_ROUND_ROBIN_EN defined: search starts at (last granted index + 1) mod 8 and wraps; pointer updates only on load.
REQ-025 Macro undefined: fixed priority per REQ-014, no pointer register; all other behaviour identical.

Structure
REQ-026 Shared package req_enc_pkg SHALL hold: N_SRC=8, IDX_W=3, CNT_W=4, FSM state enum {IDLE,HOLD}.
REQ-027 One sub-module prio_enc8 (combinational: 8-bit vector + 3-bit start index -> index + found flag); fixed mode ties start to 0.

Verification
REQ-028 Reset, then req=8'b0000_0100 for 1 cycle, out_ready=1 -> next cycle code=2, out_valid=1; following cycle out_valid=0, pend_cnt=0.
REQ-029 req=8'b1000_0011 one cycle, out_ready=1 (fixed) -> codes 0,1,7 on consecutive cycles, pend_cnt 2,1,0, then out_valid=0.
REQ-030 Grant code=5 held, out_ready=0 for 4 cycles while req=8'b0000_1000 pulses -> code stays 5, pend_cnt=1; on out_ready=1 next code=3.
REQ-031 Eneable=1, req=8'hFF pulse -> out_valid=0, pend_cnt=8, busy=1; Eneable=0, out_ready=1 -> codes 0..7 on 8 consecutive cycles.
REQ-032 ROUND_ROBIN_EN, req=8'b0000_0011 held high, out_ready=1 -> codes alternate 0,1,0,1; fixed build -> code=0 every cycle.
REQ-033 rst pulsed while out_valid=1 and pend_cnt=3 -> next cycle out_valid=0, pend_cnt=0, busy=0, no stale grant afterwards.
